line_clear: RTL

- Downstream neighbour of the piece-store stage. Runs once that stage has written a locked tetromino into board RAM.
- Scans the board bottom-up for full rows and deletes each one by shifting every row above it down by one. Row 0 is then zero-filled.
- Reports the number of rows removed for scoring and next-piece spawn logic.
- Shares the single-port board RAM: cell (x,y) lives at address y*COLS+x, 6-bit cell code, 0 = empty.

---
 rtl/line_clear_if.sv | 13 +
 rtl/line_clear.sv | 139 +++++++++++++
 2 files changed

// File: rtl/line_clear_if.sv
// line_clear_if: start/status handshake plus board RAM port for the line-clear stage.
interface line_clear_if;
  logic       start;
  logic [7:0] ram_addr;
  logic       ram_wren;
  logic [5:0] ram_wdata;
  logic [5:0] ram_q;
  logic       busy;
  logic       done;
  logic [2:0] lines_cleared;
  modport master (output start, ram_q, input ram_addr, ram_wren, ram_wdata, busy, done, lines_cleared);
  modport slave  (input start, ram_q, output ram_addr, ram_wren, ram_wdata, busy, done, lines_cleared);
endinterface

// File: rtl/line_clear.sv
// line_clear: scans the board bottom-up, deletes full rows by shifting rows above down one, zero-fills row 0.
module line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input logic         clk,
  input logic         resetn,
  line_clear_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  typedef enum logic [3:0] {
    IDLE, C_RA, C_RW, C_RS, S_RA, S_RW, S_RS, S_WA, S_WE, S_WL, T_WA, T_WE, T_WL, FIN
  } state_t;
  state_t        r_state, w_state_n;
  logic [RW-1:0] r_row, w_row_n, r_dst, w_dst_n;
  logic [CW-1:0] r_col, w_col_n;
  logic [2:0]    r_cnt, w_cnt_n, r_lines;
  logic [7:0]    r_addr, w_addr_n;
  logic [5:0]    r_wdata, w_wdata_n;
  logic          r_wren, r_busy, r_done;
  logic          w_last_col;
  function automatic logic [7:0] f_addr(input logic [RW-1:0] y, input logic [CW-1:0] x);
    return 8'(y) * 8'(COLS) + 8'(x);
  endfunction
  assign w_last_col = r_col == CW'(COLS - 1);
  // Address/data are loaded on entry to each RA/WA state so the RAM sees them for the whole access.
  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_dst_n   = r_dst;
    w_cnt_n   = r_cnt;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    case (r_state)
      IDLE: if (bus.start) begin
        w_state_n = C_RA;
        w_row_n   = RW'(ROWS - 1);
        w_col_n   = '0;
        w_cnt_n   = '0;
        w_addr_n  = f_addr(RW'(ROWS - 1), '0);
      end
      C_RA: w_state_n = C_RW;
      C_RW: w_state_n = C_RS;
      C_RS: if (bus.ram_q == '0) begin
        if (r_row == '0) w_state_n = FIN;
        else begin
          w_state_n = C_RA;
          w_row_n   = r_row - 1'b1;
          w_col_n   = '0;
          w_addr_n  = f_addr(r_row - 1'b1, '0);
        end
      end else if (!w_last_col) begin
        w_state_n = C_RA;
        w_col_n   = r_col + 1'b1;
        w_addr_n  = f_addr(r_row, r_col + 1'b1);
      end else begin
        w_cnt_n   = (r_cnt == 3'd7) ? r_cnt : r_cnt + 1'b1;
        w_dst_n   = r_row;
        w_col_n   = '0;
        w_wdata_n = '0;
        w_state_n = (r_row == '0) ? T_WA : S_RA;
        w_addr_n  = (r_row == '0) ? 8'd0 : f_addr(r_row - 1'b1, '0);
      end
      S_RA: w_state_n = S_RW;
      S_RW: w_state_n = S_RS;
      S_RS: begin
        w_state_n = S_WA;
        w_wdata_n = bus.ram_q;
        w_addr_n  = f_addr(r_dst, r_col);
      end
      S_WA: w_state_n = S_WE;
      S_WE: w_state_n = S_WL;
      S_WL: if (!w_last_col) begin
        w_state_n = S_RA;
        w_col_n   = r_col + 1'b1;
        w_addr_n  = f_addr(r_dst - 1'b1, r_col + 1'b1);
      end else if (r_dst == RW'(1)) begin
        w_state_n = T_WA;
        w_col_n   = '0;
        w_addr_n  = 8'd0;
        w_wdata_n = '0;
      end else begin
        w_state_n = S_RA;
        w_col_n   = '0;
        w_dst_n   = r_dst - 1'b1;
        w_addr_n  = f_addr(r_dst - RW'(2), '0);
      end
      T_WA: w_state_n = T_WE;
      T_WE: w_state_n = T_WL;
      T_WL: if (!w_last_col) begin
        w_state_n = T_WA;
        w_col_n   = r_col + 1'b1;
        w_addr_n  = f_addr('0, r_col + 1'b1);
      end else begin
        // the row just cleared now holds what was above it, so check it again
        w_state_n = C_RA;
        w_col_n   = '0;
        w_addr_n  = f_addr(r_row, '0);
      end
      FIN:     w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wren  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lines <= '0;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_dst   <= w_dst_n;
      r_cnt   <= w_cnt_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_wren  <= (w_state_n == S_WE) || (w_state_n == T_WE);
      r_busy  <= (w_state_n != IDLE) && (w_state_n != FIN);
      r_done  <= w_state_n == FIN;
      r_lines <= (w_state_n == FIN) ? w_cnt_n : r_lines;
    end
  end
  assign bus.ram_addr      = r_addr;
  assign bus.ram_wren      = r_wren;
  assign bus.ram_wdata     = r_wdata;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.lines_cleared = r_lines;
endmodule
